// File: rtl/s10077_pkg.sv
// Shared types and default constants for the S10077 sensor model.
//   state_t  : readout sequencer states
//   NPIX_DEF : default pixels per frame
//   VW_DEF   : default VIDEO width
//   FRAME_W  : FRAME_CNT width
package s10077_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DELAY   = 2'd1,
        READOUT = 2'd2,
        EOSP    = 2'd3
    } state_t;

    localparam int unsigned NPIX_DEF = 1024;
    localparam int unsigned VW_DEF   = 12;
    localparam int unsigned FRAME_W  = 16;

endpackage

// File: rtl/s10077_sensor_model_sclk_sync.sv
// Brings SENSOR_CLK and ST into the FPGA_CLK domain.
//   FPGA_CLK, FPGA_RST : clock, synchronous active-high reset
//   SENSOR_CLK, ST     : asynchronous inputs from the sensor driver
//   tick               : one-cycle strobe on each synchronised SENSOR_CLK rise
//   st_s               : synchronised ST
module s10077_sensor_model_sclk_sync (
    input  logic FPGA_CLK,
    input  logic FPGA_RST,
    input  logic SENSOR_CLK,
    input  logic ST,
    output logic tick,
    output logic st_s
);

    logic sclk_s1;
    logic sclk_s2;
    logic sclk_s3;
    logic st_s1;
    logic st_s2;

    // Two-flop synchronisers; sclk_s3 is the edge-detect history stage.
    always_ff @(posedge FPGA_CLK) begin
        if (FPGA_RST) begin
            sclk_s1 <= 1'b0;
            sclk_s2 <= 1'b0;
            sclk_s3 <= 1'b0;
            st_s1   <= 1'b0;
            st_s2   <= 1'b0;
        end else begin
            sclk_s1 <= SENSOR_CLK;
            sclk_s2 <= sclk_s1;
            sclk_s3 <= sclk_s2;
            st_s1   <= ST;
            st_s2   <= st_s1;
        end
    end

    assign tick = sclk_s2 & ~sclk_s3;
    assign st_s = st_s2;

endmodule

// File: rtl/s10077_sensor_model.sv
// Behavioural responder model of the S10077 linear image sensor.
// Each ST fall seen at a SENSOR_CLK tick produces one frame of NPIX EOC
// pulses followed by one EOS pulse, with VIDEO = pixel index + frame count.
//   FPGA_CLK, FPGA_RST : clock, synchronous active-high reset
//   SENSOR_CLK, ST     : asynchronous sensor clock and start pulse
//   EOC, EOS           : end-of-conversion / end-of-scan pulses (registered)
//   VIDEO              : current pixel value (registered)
//   FRAME_CNT          : completed frames, wrapping
//   OVERRUN            : sticky, ST rose while a frame was in progress
module s10077_sensor_model
    import s10077_pkg::*;
#(
    parameter int unsigned NPIX         = NPIX_DEF,
    parameter int unsigned CLKS_PER_PIX = 4,
    parameter int unsigned START_DLY    = 48,
    parameter int unsigned VW           = VW_DEF
) (
    input  logic                FPGA_CLK,
    input  logic                FPGA_RST,
    input  logic                SENSOR_CLK,
    input  logic                ST,
    output logic                EOC,
    output logic                EOS,
    output logic [VW-1:0]       VIDEO,
    output logic [FRAME_W-1:0]  FRAME_CNT,
    output logic                OVERRUN
);

    localparam int unsigned PIX_W = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int unsigned SUB_W = $clog2(CLKS_PER_PIX);
    localparam int unsigned DLY_W = $clog2(START_DLY + 1);

    logic tick;
    logic st_s;

    s10077_sensor_model_sclk_sync u_sync (
        .FPGA_CLK   (FPGA_CLK),
        .FPGA_RST   (FPGA_RST),
        .SENSOR_CLK (SENSOR_CLK),
        .ST         (ST),
        .tick       (tick),
        .st_s       (st_s)
    );

    state_t             state_q, state_d;
    logic [DLY_W-1:0]   dly_q, dly_d;
    logic [SUB_W-1:0]   sub_q, sub_d;
    logic [PIX_W-1:0]   pix_q, pix_d;
    logic               st_prev_q, st_prev_d;
    logic               eoc_d, eos_d, ovr_d;
    logic [VW-1:0]      video_d;
    logic [FRAME_W-1:0] fc_d;
    logic               st_fall, st_rise;

    assign st_fall = st_prev_q & ~st_s;
    assign st_rise = ~st_prev_q & st_s;

    // State and output registers.
    always_ff @(posedge FPGA_CLK) begin
        if (FPGA_RST) begin
            state_q   <= IDLE;
            dly_q     <= '0;
            sub_q     <= '0;
            pix_q     <= '0;
            st_prev_q <= 1'b0;
            EOC       <= 1'b0;
            EOS       <= 1'b0;
            VIDEO     <= '0;
            FRAME_CNT <= '0;
            OVERRUN   <= 1'b0;
        end else begin
            state_q   <= state_d;
            dly_q     <= dly_d;
            sub_q     <= sub_d;
            pix_q     <= pix_d;
            st_prev_q <= st_prev_d;
            EOC       <= eoc_d;
            EOS       <= eos_d;
            VIDEO     <= video_d;
            FRAME_CNT <= fc_d;
            OVERRUN   <= ovr_d;
        end
    end

    // Sequencer; everything holds between ticks.
    // READOUT is entered one tick early so that the sub=0 tick raises EOC
    // exactly START_DLY ticks after the ST fall.
    always_comb begin
        state_d   = state_q;
        dly_d     = dly_q;
        sub_d     = sub_q;
        pix_d     = pix_q;
        st_prev_d = st_prev_q;
        eoc_d     = EOC;
        eos_d     = EOS;
        video_d   = VIDEO;
        fc_d      = FRAME_CNT;
        ovr_d     = OVERRUN;

        if (tick) begin
            st_prev_d = st_s;
            if (st_rise && (state_q != IDLE)) begin
                ovr_d = 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (st_fall) begin
                        dly_d   = DLY_W'(START_DLY - 1);
                        sub_d   = '0;
                        pix_d   = '0;
                        state_d = (START_DLY == 1) ? READOUT : DELAY;
                    end
                end
                DELAY: begin
                    if (dly_q <= DLY_W'(1)) begin
                        state_d = READOUT;
                    end else begin
                        dly_d = dly_q - DLY_W'(1);
                    end
                end
                READOUT: begin
                    if (sub_q == SUB_W'(0)) begin
                        eoc_d   = 1'b1;
                        video_d = VW'(pix_q) + FRAME_CNT[VW-1:0];
                    end else if (sub_q == SUB_W'(1)) begin
                        eoc_d = 1'b0;
                    end
                    if (sub_q == SUB_W'(CLKS_PER_PIX - 1)) begin
                        sub_d = '0;
                        if (pix_q == PIX_W'(NPIX - 1)) begin
                            state_d = EOSP;
                        end else begin
                            pix_d = pix_q + PIX_W'(1);
                        end
                    end else begin
                        sub_d = sub_q + SUB_W'(1);
                    end
                end
                EOSP: begin
                    // First EOSP tick raises EOS and counts the frame; second drops it.
                    if (!EOS) begin
                        eos_d = 1'b1;
                        fc_d  = FRAME_CNT + FRAME_W'(1);
                    end else begin
                        eos_d   = 1'b0;
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_s10077_sensor_model.sv
// Directed self-checking bench for s10077_sensor_model with a short frame
// (NPIX=8, CLKS_PER_PIX=4, START_DLY=3, SENSOR_CLK = 16 FPGA_CLK).
module tb_s10077_sensor_model;

    localparam int T_NPIX = 8;
    localparam int T_CPP  = 4;
    localparam int T_DLY  = 3;
    localparam int T_EOS  = T_DLY + T_NPIX * T_CPP;   // tick offset of EOS
    localparam int T_END  = T_EOS + 1;                // frame back in IDLE

    logic        FPGA_CLK = 1'b0;
    logic        FPGA_RST = 1'b1;
    logic        SENSOR_CLK = 1'b0;
    logic        ST = 1'b0;
    logic        EOC;
    logic        EOS;
    logic [11:0] VIDEO;
    logic [15:0] FRAME_CNT;
    logic        OVERRUN;

    int n_checks = 0;
    int n_pass   = 0;

    s10077_sensor_model #(
        .NPIX         (T_NPIX),
        .CLKS_PER_PIX (T_CPP),
        .START_DLY    (T_DLY),
        .VW           (12)
    ) dut (
        .FPGA_CLK   (FPGA_CLK),
        .FPGA_RST   (FPGA_RST),
        .SENSOR_CLK (SENSOR_CLK),
        .ST         (ST),
        .EOC        (EOC),
        .EOS        (EOS),
        .VIDEO      (VIDEO),
        .FRAME_CNT  (FRAME_CNT),
        .OVERRUN    (OVERRUN)
    );

    always #5 FPGA_CLK = ~FPGA_CLK;

    // Passive monitor: EOC edges per frame, EOC high cycles, EOS rises, overlap.
    logic eoc_d = 1'b0;
    logic eos_d = 1'b0;
    int   eoc_run = 0;
    int   eoc_last = 0;
    int   eoc_hi_cyc = 0;
    int   eos_rises = 0;
    int   overlap = 0;

    always @(posedge FPGA_CLK) begin
        eoc_d <= EOC;
        eos_d <= EOS;
        if (EOC) eoc_hi_cyc <= eoc_hi_cyc + 1;
        if (EOC && EOS) overlap <= overlap + 1;
        if (FPGA_RST) begin
            eoc_run <= 0;
        end else if (EOS && !eos_d) begin
            eoc_last  <= eoc_run;
            eoc_run   <= 0;
            eos_rises <= eos_rises + 1;
        end else if (EOC && !eoc_d) begin
            eoc_run <= eoc_run + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // One SENSOR_CLK period starting and ending on a falling FPGA_CLK edge.
    task automatic do_tick();
        SENSOR_CLK = 1'b1;
        repeat (8) @(negedge FPGA_CLK);
        SENSOR_CLK = 1'b0;
        repeat (8) @(negedge FPGA_CLK);
    endtask

    task automatic prime_st();
        ST = 1'b1;
        repeat (10) do_tick();
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, " eoc"},   32'(EOC),       32'd0);
        chk({tag, " eos"},   32'(EOS),       32'd0);
        chk({tag, " video"}, 32'(VIDEO),     32'd0);
        chk({tag, " fcnt"},  32'(FRAME_CNT), 32'd0);
        chk({tag, " ovr"},   32'(OVERRUN),   32'd0);
    endtask

    // Drops ST and walks ticks 0..last_k of a frame against the expected schedule.
    task automatic frame(input string tag, input int fc0, input int vprev,
                         input int last_k, input bit ovr, input int stall_k);
        int hi0;
        int p;
        logic e_eoc, e_eos;
        int e_vid, e_fc;
        hi0 = eoc_hi_cyc;
        ST = 1'b0;
        for (int k = 0; k <= last_k; k++) begin
            if (ovr && k == 5)  ST = 1'b1;
            if (ovr && k == 11) ST = 1'b0;
            do_tick();
            e_eoc = (k >= T_DLY) && (k < T_EOS) && (((k - T_DLY) % T_CPP) == 0);
            e_eos = (k == T_EOS);
            e_fc  = (k >= T_EOS) ? fc0 + 1 : fc0;
            if (k < T_DLY) begin
                e_vid = vprev;
            end else begin
                p = (k - T_DLY) / T_CPP;
                if (p > T_NPIX - 1) p = T_NPIX - 1;
                e_vid = (fc0 + p) & 12'hFFF;
            end
            chk($sformatf("%s eoc k%0d", tag, k),   32'(EOC),       32'(e_eoc));
            chk($sformatf("%s eos k%0d", tag, k),   32'(EOS),       32'(e_eos));
            chk($sformatf("%s video k%0d", tag, k), 32'(VIDEO),     32'(e_vid));
            chk($sformatf("%s fcnt k%0d", tag, k),  32'(FRAME_CNT), 32'(e_fc));
            if (ovr) chk($sformatf("%s ovr k%0d", tag, k), 32'(OVERRUN), 32'(k >= 5));
            if (k == stall_k) begin
                repeat (200) @(negedge FPGA_CLK);
                chk($sformatf("%s hold eoc k%0d", tag, k),   32'(EOC),       32'(e_eoc));
                chk($sformatf("%s hold eos k%0d", tag, k),   32'(EOS),       32'(e_eos));
                chk($sformatf("%s hold video k%0d", tag, k), 32'(VIDEO),     32'(e_vid));
                chk($sformatf("%s hold fcnt k%0d", tag, k),  32'(FRAME_CNT), 32'(e_fc));
            end
        end
        if (last_k >= T_END) begin
            chk({tag, " eoc per frame"}, 32'(eoc_last), 32'(T_NPIX));
            chk({tag, " eoc hi cycles"}, 32'(eoc_hi_cyc - hi0), 32'(T_NPIX * 16));
        end
    endtask

    initial begin
        int eos0;

        repeat (3) @(negedge FPGA_CLK);
        FPGA_RST = 1'b0;
        @(negedge FPGA_CLK);
        chk_outputs_zero("reset");

        // Single frame: VIDEO 0..7, FRAME_CNT 1.
        prime_st();
        chk("idle eoc", 32'(EOC), 32'd0);
        frame("f1", 0, 0, T_END, 1'b0, -1);
        chk("f1 fcnt end", 32'(FRAME_CNT), 32'd1);

        // Second frame: VIDEO 1..8, no overrun.
        prime_st();
        frame("f2", 1, 7, T_END, 1'b0, -1);
        chk("f2 fcnt end", 32'(FRAME_CNT), 32'd2);
        chk("f2 ovr", 32'(OVERRUN), 32'd0);

        // ST re-raised and dropped mid-frame: frame completes, OVERRUN, no queued frame.
        prime_st();
        frame("f3", 2, 8, T_END, 1'b1, -1);
        eos0 = eos_rises;
        repeat (40) do_tick();
        chk("f3 no extra eos", 32'(eos_rises), 32'(eos0));
        chk("f3 fcnt end", 32'(FRAME_CNT), 32'd3);
        chk("f3 ovr sticky", 32'(OVERRUN), 32'd1);

        // Reset after the 4th EOC rises: everything clears, no EOS for the aborted frame.
        prime_st();
        frame("f4", 3, 9, T_DLY + 3 * T_CPP, 1'b0, -1);
        chk("f4 eoc before rst", 32'(EOC), 32'd1);
        FPGA_RST = 1'b1;
        @(negedge FPGA_CLK);
        FPGA_RST = 1'b0;
        chk_outputs_zero("midrst");
        eos0 = eos_rises;
        repeat (40) do_tick();
        chk("midrst no eos", 32'(eos_rises), 32'(eos0));
        chk("midrst fcnt", 32'(FRAME_CNT), 32'd0);
        prime_st();
        frame("f5", 0, 0, T_END, 1'b0, -1);

        // SENSOR_CLK stopped mid-READOUT: outputs hold, sequence resumes on next tick.
        prime_st();
        frame("f6", 1, 7, T_END, 1'b0, 9);
        chk("f6 fcnt end", 32'(FRAME_CNT), 32'd2);

        chk("eoc eos overlap", 32'(overlap), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
